udp_encoder: RTL and testbench
==============================

Name: udp_encoder

Overview:
- Transmit-side counterpart of the UDP header decoder.
- Accepts a per-frame header command (source port, destination port, payload length) and a 64-bit frame beat stream with the UDP header slots left as placeholders.
- Writes srcPort/destPort into beat 4 and length/checksum into beat 5, at the same bit positions the decoder reads, so encoder-to-decoder loopback is transparent.
- Sits between the IP-layer frame builder and the MAC transmit path; one output register stage with valid/ready backpressure.

Parameters:
- PORT_BEAT, 4, beat index (0-based) carrying the ports: srcPort in [47:32], destPort in [63:48].
- LEN_BEAT, 5, beat index carrying length in [15:0] and checksum in [31:16]. Must be greater than PORT_BEAT and at most 14.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hdr_valid  in  1  header command valid.
- hdr_ready  out  1  header command accepted when hdr_valid && hdr_ready.
- hdr_src_port  in  16  UDP source port.
- hdr_dst_port  in  16  UDP destination port.
- hdr_payload_len  in  16  payload byte count, excluding the 8-byte UDP header.
- in_data  in  64  frame beat, placeholders at the header slots.
- in_valid  in  1  input beat valid.
- in_last  in  1  final beat of the frame.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- out_data  out  64  frame beat with header inserted.
- out_valid  out  1  output beat valid.
- out_last  out  1  final beat of the frame.
- out_ready  in  1  downstream accepts the beat.
- short_frame  out  1  one-cycle pulse: frame ended before LEN_BEAT was reached.

Behaviour:
- Reset values:
  - state IDLE; beat_cnt 0; latched src, dst and length 0.
  - out_data 0; out_valid 0; out_last 0; short_frame 0.
  - A beat held in the output register at reset is discarded. A partial frame is not completed.
- FSM states: IDLE, STREAM.
- IDLE:
  - hdr_ready=1, in_ready=0.
  - On header handshake: latch ports; udp_len = hdr_payload_len + 8, modulo 2^16 (wraps, no flag); beat_cnt=0; go to STREAM.
- STREAM:
  - hdr_ready=0; in_ready = !out_valid || out_ready.
  - On each input handshake, load the output register:
    - beat_cnt==PORT_BEAT: out_data = {dst, src, in_data[31:0]}.
    - beat_cnt==LEN_BEAT: out_data = {in_data[63:32], 16'h0000, udp_len}. Checksum is always 0 (IPv4 "no checksum").
    - Otherwise: out_data = in_data unmodified.
    - out_last = in_last; out_valid = 1.
  - beat_cnt increments per accepted beat and saturates at 15. Beats past 15 pass unmodified.
  - Accepted beat with in_last=1: return to IDLE on the next cycle.
    - If beat_cnt < LEN_BEAT at that beat, pulse short_frame in the same cycle out_valid first presents that last beat.
    - A short frame still gets any slot it reached (e.g. beat 4) modified.
- Output register:
  - Cleared (out_valid=0) on out_ready with no new input handshake.
  - Load and drain in the same cycle sustain 1 beat/cycle.
  - out_valid && !out_ready holds out_data/out_last stable.
- Latency: beat accepted at cycle N is presented at N+1.
- Overlap: in IDLE the next header may be accepted while the previous last beat is still held in the output register. No input beat is accepted in IDLE.
- Single-beat frame (in_last at beat 0): passed through unmodified, short_frame pulses.
- in_data/in_last are ignored when in_valid=0. The header is sampled only at the handshake, so later changes to hdr_* have no effect on the frame in flight.

Test Plan:
- Header src=0x1234, dst=0x5678, len=0x0010; 8-beat frame in_data=beat index replicated, out_ready=1 -> beat 4 = 0x5678_1234_0404_0404, beat 5 = 0x0505_0505_0000_0018, others unchanged, out_last on beat 7, 1-cycle latency, no short_frame.
- Same frame with out_ready toggling 1,0,0,1 -> out_data held stable while stalled; no beat lost or duplicated; in_ready low exactly while out_valid && !out_ready.
- 5-beat frame (last at beat 4) -> ports inserted in beat 4, short_frame pulses with beat 4 on the output, FSM back in IDLE.
- hdr_payload_len=0xFFFC -> length field 0x0004 (wrap); back-to-back frames, second header accepted while first last beat stalled -> second frame fields correct.
- Assert rst during beat 3 of a frame -> next cycle out_valid=0, hdr_ready=1; new frame encodes correctly from beat 0.
- Loopback into the UDP decoder -> decoder srcPort/destPort/length/checksum equal 0x1234/0x5678/0x0018/0x0000.

Source files
------------

// File: rtl/udp_encoder_if.sv
// Handshake and data bundle between the IP frame builder, the UDP encoder and the MAC transmit path.
// All three channels use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface udp_encoder_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [15:0] hdr_src_port;
  logic [15:0] hdr_dst_port;
  logic [15:0] hdr_payload_len;

  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;

  logic [63:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  logic        short_frame;

  modport master (
    output hdr_valid, hdr_src_port, hdr_dst_port, hdr_payload_len,
    output in_data, in_valid, in_last, out_ready,
    input  hdr_ready, in_ready, out_data, out_valid, out_last, short_frame
  );

  modport slave (
    input  hdr_valid, hdr_src_port, hdr_dst_port, hdr_payload_len,
    input  in_data, in_valid, in_last, out_ready,
    output hdr_ready, in_ready, out_data, out_valid, out_last, short_frame
  );
endinterface

// File: rtl/udp_encoder.sv
// UDP header encoder: inserts ports into beat PORT_BEAT and length/zero checksum into beat LEN_BEAT
// of a 64-bit frame stream, behind a single output register with valid/ready backpressure.
module udp_encoder #(
  parameter int PORT_BEAT = 4,
  parameter int LEN_BEAT  = 5
) (
  input  logic            clk,
  input  logic            rst,
  udp_encoder_if.slave    bus,
  output logic            dbg_state_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam logic [3:0] PORT_IDX = 4'(PORT_BEAT);
  localparam logic [3:0] LEN_IDX  = 4'(LEN_BEAT);

  state_e      state_q, state_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        short_q, short_d;

  logic        hdr_ready_w;
  logic        in_ready_w;
  logic        hdr_fire;
  logic        in_fire;

  assign hdr_fire = bus.hdr_valid && hdr_ready_w;
  assign in_fire  = bus.in_valid && in_ready_w;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hdr_fire) state_d = STREAM;
      STREAM:  if (in_fire && bus.in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a new beat may enter whenever the output register is empty or draining.
  always_comb begin
    hdr_ready_w = 1'b0;
    in_ready_w  = 1'b0;
    case (state_q)
      IDLE:    hdr_ready_w = 1'b1;
      STREAM:  in_ready_w  = !out_valid_q || bus.out_ready;
      default: ;
    endcase
  end

  // Header latch, beat counter and output register next values
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    short_d     = 1'b0;

    if (hdr_fire) begin
      src_d      = bus.hdr_src_port;
      dst_d      = bus.hdr_dst_port;
      len_d      = bus.hdr_payload_len + 16'd8;
      beat_cnt_d = 4'd0;
    end

    if (in_fire) begin
      if (beat_cnt_q == PORT_IDX)
        out_data_d = {dst_q, src_q, bus.in_data[31:0]};
      else if (beat_cnt_q == LEN_IDX)
        out_data_d = {bus.in_data[63:32], 16'h0000, len_q};
      else
        out_data_d = bus.in_data;
      out_valid_d = 1'b1;
      out_last_d  = bus.in_last;
      // Registered alongside the last beat so the pulse lines up with its presentation.
      short_d     = bus.in_last && (beat_cnt_q < LEN_IDX);
      if (beat_cnt_q != 4'd15) beat_cnt_d = beat_cnt_q + 4'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= 4'd0;
      src_q       <= 16'd0;
      dst_q       <= 16'd0;
      len_q       <= 16'd0;
      out_data_q  <= 64'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      short_q     <= short_d;
    end
  end

  assign bus.hdr_ready   = hdr_ready_w;
  assign bus.in_ready    = in_ready_w;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.short_frame = short_q;
  assign dbg_state_o     = (state_q == STREAM);

endmodule

// File: tb/tb_udp_encoder.sv
// Bench for udp_encoder: directed frames with literal expectations plus randomized frames
// checked every cycle against a frame-level model of the header insertion rules.
module tb_udp_encoder;

  localparam int PORT_BEAT = 4;
  localparam int LEN_BEAT  = 5;

  logic clk;
  logic rst;
  logic dbg_state;

  udp_encoder_if bus ();

  udp_encoder #(.PORT_BEAT(PORT_BEAT), .LEN_BEAT(LEN_BEAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- downstream ready ----------------
  int         rdy_mode = 0;  // 0 always, 1 random, 2 pattern 1,0,0,1, 3 stalled
  logic [3:0] rdy_pat  = 4'b1001;
  int         pat_i    = 0;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      2: begin
        bus.out_ready = rdy_pat[pat_i];
        pat_i = (pat_i + 1) % 4;
      end
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- model + scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [63:0] cap_data[$];
  logic        cap_last[$];
  logic [15:0] m_src, m_dst, m_len;
  int          m_idx    = 0;
  logic        in_frame = 1'b0;
  logic        exp_short = 1'b0;
  int          short_cnt = 0;
  logic        held_v = 1'b0;
  logic [64:0] held;
  logic [64:0] e;
  logic [63:0] m_out;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_frame  = 1'b0;
      exp_short = 1'b0;
      held_v    = 1'b0;
    end else begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("short_frame", 64'(bus.short_frame), 64'(exp_short));
      chk("hdr_ready", 64'(bus.hdr_ready), 64'(!in_frame));
      chk("in_ready", 64'(bus.in_ready), 64'(in_frame && !(bus.out_valid && !bus.out_ready)));
      chk("dbg_state", 64'(dbg_state), 64'(in_frame));
      if (bus.short_frame) short_cnt++;
      if (held_v) chk("stall_hold", {bus.out_last, bus.out_data}, held);
      held_v = bus.out_valid && !bus.out_ready;
      held   = {bus.out_last, bus.out_data};

      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e[63:0]);
        chk("out_last", 64'(bus.out_last), 64'(e[64]));
        cap_data.push_back(bus.out_data);
        cap_last.push_back(bus.out_last);
      end

      exp_short = 1'b0;
      if (bus.hdr_valid && bus.hdr_ready) begin
        m_src    = bus.hdr_src_port;
        m_dst    = bus.hdr_dst_port;
        m_len    = bus.hdr_payload_len + 16'd8;
        m_idx    = 0;
        in_frame = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (m_idx == PORT_BEAT)     m_out = {m_dst, m_src, bus.in_data[31:0]};
        else if (m_idx == LEN_BEAT) m_out = {bus.in_data[63:32], 16'h0000, m_len};
        else                        m_out = bus.in_data;
        exp_q.push_back({bus.in_last, m_out});
        if (bus.in_last) begin
          exp_short = (m_idx < LEN_BEAT);
          in_frame  = 1'b0;
        end
        m_idx++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic hdr_stalled;

  task automatic send_header(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    int n;
    bus.hdr_valid = 1'b1;
    bus.hdr_src_port = s;
    bus.hdr_dst_port = d;
    bus.hdr_payload_len = l;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.hdr_ready) break;
    end
    if (n == 300) chk("hdr_timeout", 64'd0, 64'd1);
    hdr_stalled = bus.out_valid && !bus.out_ready;
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    bus.hdr_src_port = 16'($urandom);
    bus.hdr_dst_port = 16'($urandom);
    bus.hdr_payload_len = 16'($urandom);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (n == 300) chk("beat_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beats(input int n, input bit idx_pat, input bit gaps);
    logic [7:0]  b;
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      b = 8'(i);
      d = idx_pat ? {8{b}} : {$urandom, $urandom};
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(d, i == n - 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    if (n == 500) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    cap_data.delete();
    cap_last.delete();
    short_cnt = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.hdr_valid = 1'b0;
    bus.hdr_src_port = 16'd0;
    bus.hdr_dst_port = 16'd0;
    bus.hdr_payload_len = 16'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 64'd0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_data", bus.out_data, 64'd0);
    chk("reset_out_last", 64'(bus.out_last), 64'd0);
    chk("reset_hdr_ready", 64'(bus.hdr_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic 8-beat frame, full throughput, then loopback decode of the header slots
    rdy_mode = 0;
    clear_log();
    send_header(16'h1234, 16'h5678, 16'h0010);
    send_beats(8, 1'b1, 1'b0);
    wait_drain();
    chk("basic_count", 64'(cap_data.size()), 64'd8);
    if (cap_data.size() == 8) begin
      chk("basic_beat3", cap_data[3], 64'h0303_0303_0303_0303);
      chk("basic_beat4", cap_data[4], 64'h5678_1234_0404_0404);
      chk("basic_beat5", cap_data[5], 64'h0505_0505_0000_0018);
      chk("basic_last7", 64'(cap_last[7]), 64'd1);
      chk("basic_last6", 64'(cap_last[6]), 64'd0);
      chk("loop_src", 64'(cap_data[4][47:32]), 64'h1234);
      chk("loop_dst", 64'(cap_data[4][63:48]), 64'h5678);
      chk("loop_len", 64'(cap_data[5][15:0]), 64'h0018);
      chk("loop_csum", 64'(cap_data[5][31:16]), 64'h0000);
    end
    chk("basic_no_short", 64'(short_cnt), 64'd0);

    // Same frame under a 1,0,0,1 ready pattern
    rdy_mode = 2;
    clear_log();
    send_header(16'h1234, 16'h5678, 16'h0010);
    send_beats(8, 1'b1, 1'b0);
    wait_drain();
    rdy_mode = 0;
    chk("stall_count", 64'(cap_data.size()), 64'd8);
    if (cap_data.size() == 8) begin
      chk("stall_beat4", cap_data[4], 64'h5678_1234_0404_0404);
      chk("stall_beat5", cap_data[5], 64'h0505_0505_0000_0018);
    end

    // Short frame ending on the port beat
    clear_log();
    send_header(16'h1234, 16'h5678, 16'h0010);
    send_beats(5, 1'b1, 1'b0);
    wait_drain();
    chk("short_count", 64'(cap_data.size()), 64'd5);
    if (cap_data.size() == 5) chk("short_beat4", cap_data[4], 64'h5678_1234_0404_0404);
    chk("short_pulses", 64'(short_cnt), 64'd1);

    // Single-beat frame passes through unmodified
    clear_log();
    send_header(16'h0001, 16'h0002, 16'h0003);
    send_beat(64'hDEAD_BEEF_0123_4567, 1'b1);
    wait_drain();
    if (cap_data.size() == 1) chk("single_beat", cap_data[0], 64'hDEAD_BEEF_0123_4567);
    chk("single_pulses", 64'(short_cnt), 64'd1);

    // Length wrap, and a second header accepted while the first last beat is stalled
    clear_log();
    send_header(16'h1111, 16'h2222, 16'hFFFC);
    send_beats(6, 1'b1, 1'b0);
    rdy_mode = 3;
    send_header(16'hAAAA, 16'hBBBB, 16'h0100);
    chk("hdr_during_stall", 64'(hdr_stalled), 64'd1);
    rdy_mode = 0;
    send_beats(8, 1'b1, 1'b0);
    wait_drain();
    chk("b2b_count", 64'(cap_data.size()), 64'd14);
    if (cap_data.size() == 14) begin
      chk("wrap_len", cap_data[5], 64'h0505_0505_0000_0004);
      chk("b2b_beat4", cap_data[10], 64'hBBBB_AAAA_0404_0404);
      chk("b2b_beat5", cap_data[11], 64'h0505_0505_0000_0108);
    end

    // Reset in the middle of a frame, then a clean frame
    send_header(16'h1234, 16'h5678, 16'h0010);
    send_beats(3, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0303_0303_0303_0303;
    bus.in_last  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_hdr_ready", 64'(bus.hdr_ready), 64'd1);
    @(posedge clk);
    #1;
    clear_log();
    send_header(16'h1234, 16'h5678, 16'h0010);
    send_beats(8, 1'b1, 1'b0);
    wait_drain();
    if (cap_data.size() == 8) begin
      chk("post_rst_beat4", cap_data[4], 64'h5678_1234_0404_0404);
      chk("post_rst_beat5", cap_data[5], 64'h0505_0505_0000_0018);
    end else begin
      chk("post_rst_count", 64'(cap_data.size()), 64'd8);
    end

    // Randomized frames, random backpressure and input gaps, up to 20 beats
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      send_header(16'($urandom), 16'($urandom), 16'($urandom));
      send_beats($urandom_range(1, 20), 1'b0, 1'b1);
    end
    wait_drain();
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
